// File: rtl/wave_gen_dds.sv
// Direct digital synthesis waveform generator: phase accumulator, four
// waveform shapes, amplitude scaling, two-stage output pipeline.
module wave_gen_dds #(
  parameter int                 DATA_W  = 8,
  parameter int                 PHASE_W = 32,
  parameter logic [PHASE_W-1:0] FTW_RST = 1374
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               phase_clr,
  input  logic               cfg_load,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [1:0]         mode,
  input  logic [7:0]         amp,
  output logic [DATA_W-1:0]  value,
  output logic               step_pulse,
  output logic               wrap_pulse
);

  localparam int  N    = 1 << DATA_W;
  localparam real PI   = 3.14159265358979323846;
  localparam real MAXR = real'(N - 1);

  localparam logic [DATA_W-1:0] MAX = '1;
  localparam logic [DATA_W-1:0] MID =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] sin_rom [N];

  for (genvar g = 0; g < N; g++) begin : g_sin
    localparam real ANG = 2.0 * PI * g / N;
    localparam int  V   =
      $rtoi(MAXR / 2.0 * (1.0 + $sin(ANG)) + 0.5);
    assign sin_rom[g] = V[DATA_W-1:0];
  end

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic [PHASE_W-1:0] ftw_a_q;
  logic [1:0]         mode_a_q;
  logic [7:0]         amp_a_q;

  logic [DATA_W-1:0]  idx_prev_q;
  logic [DATA_W-1:0]  raw_q, raw_d;
  logic [7:0]         amp_s1_q;
  logic               step_s1_q;
  logic               wrap_s1_q;

  logic [DATA_W-1:0]  value_q, value_d;
  logic               step_q;
  logic               wrap_p_q;

  logic [PHASE_W:0]   sum;
  logic [DATA_W-1:0]  idx;
  logic [DATA_W-1:0]  tri_up;

  assign sum    = {1'b0, phase_q} + {1'b0, ftw_a_q};
  assign idx    = phase_q[PHASE_W-1 -: DATA_W];
  assign tri_up = {idx[DATA_W-2:0], 1'b0};

  // Clear beats accumulate; only a real carry-out marks a wrap.
  always_comb begin
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (phase_clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = sum[PHASE_W-1:0];
      wrap_d  = sum[PHASE_W];
    end
  end

  always_comb begin
    raw_d = '0;
    unique case (mode_a_q)
      2'd0: raw_d = sin_rom[idx];
      2'd1: raw_d = idx[DATA_W-1] ? ~tri_up : tri_up;
      2'd2: raw_d = idx;
      2'd3: raw_d = idx[DATA_W-1] ? '0 : MAX;
    endcase
  end

  logic signed [DATA_W:0]    diff;
  logic signed [9:0]         gain;
  logic signed [DATA_W+10:0] prod;

  always_comb begin
    diff    = $signed({1'b0, raw_q}) - $signed({1'b0, MID});
    gain    = $signed({1'b0, {1'b0, amp_s1_q} + 9'd1});
    prod    = diff * gain;
    value_d = MID + DATA_W'(prod >>> 8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      wrap_q   <= 1'b0;
      ftw_a_q  <= FTW_RST;
      mode_a_q <= 2'd0;
      amp_a_q  <= 8'hFF;
    end else begin
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      if (cfg_load) begin
        ftw_a_q  <= ftw;
        mode_a_q <= mode;
        amp_a_q  <= amp;
      end
    end
  end

  // Amplitude travels with its sample so mode and amp share latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_prev_q <= '0;
      raw_q      <= MID;
      amp_s1_q   <= 8'hFF;
      step_s1_q  <= 1'b0;
      wrap_s1_q  <= 1'b0;
    end else begin
      idx_prev_q <= idx;
      raw_q      <= raw_d;
      amp_s1_q   <= amp_a_q;
      step_s1_q  <= (idx != idx_prev_q);
      wrap_s1_q  <= wrap_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= MID;
      step_q   <= 1'b0;
      wrap_p_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      step_q   <= step_s1_q;
      wrap_p_q <= wrap_s1_q;
    end
  end

  assign value      = value_q;
  assign step_pulse = step_q;
  assign wrap_pulse = wrap_p_q;

endmodule

// File: tb/tb_wave_gen_dds.sv
// Randomized check of wave_gen_dds against a per-cycle state history
// model: the output at edge n reflects the architectural state of edge n-2.
module tb_wave_gen_dds;

  localparam int     DW      = 8;
  localparam int     PW      = 32;
  localparam longint FTW_RST = 1374;
  localparam longint P2      = 64'h1_0000_0000;
  localparam real    PI      = 3.14159265358979323846;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          phase_clr;
  logic          cfg_load;
  logic [PW-1:0] ftw;
  logic [1:0]    mode;
  logic [7:0]    amp;
  logic [DW-1:0] value;
  logic          step_pulse;
  logic          wrap_pulse;

  wave_gen_dds #(
    .DATA_W (DW),
    .PHASE_W(PW),
    .FTW_RST(32'd1374)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .phase_clr (phase_clr),
    .cfg_load  (cfg_load),
    .ftw       (ftw),
    .mode      (mode),
    .amp       (amp),
    .value     (value),
    .step_pulse(step_pulse),
    .wrap_pulse(wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint ph;
    bit     wr;
    longint ftw;
    int     mode;
    int     amp;
  } st_t;

  st_t cur;
  st_t hist[$];
  int  n_chk;
  int  n_fail;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sine_ref(int i);
    return $rtoi(255.0 / 2.0 * (1.0 + $sin(2.0 * PI * i / 256)) + 0.5);
  endfunction

  function automatic int idx_of(st_t s);
    return int'((s.ph >> 24) & 255);
  endfunction

  function automatic int exp_val(st_t s);
    int i, raw, d, p, q;
    i = idx_of(s);
    case (s.mode)
      0: raw = sine_ref(i);
      1: raw = (i < 128) ? 2 * i : 255 - 2 * (i - 128);
      2: raw = i;
      default: raw = (i < 128) ? 255 : 0;
    endcase
    d = raw - 128;
    p = d * (s.amp + 1);
    q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    return 128 + q;
  endfunction

  task automatic model_reset();
    cur = '{ph: 0, wr: 0, ftw: FTW_RST, mode: 0, amp: 255};
    hist = {};
    repeat (4) hist.push_front(cur);
  endtask

  task automatic model_edge();
    st_t    nx;
    longint s;
    nx = cur;
    nx.wr = 0;
    if (phase_clr) begin
      nx.ph = 0;
    end else if (en) begin
      s = cur.ph + cur.ftw;
      nx.wr = (s >= P2);
      nx.ph = s % P2;
    end
    if (cfg_load) begin
      nx.ftw  = longint'(ftw);
      nx.mode = int'(mode);
      nx.amp  = int'(amp);
    end
    cur = nx;
    hist.push_front(cur);
    void'(hist.pop_back());
  endtask

  task automatic compare();
    st_t s, p;
    s = hist[2];
    p = hist[3];
    chk("value", value, exp_val(s));
    chk("step", step_pulse, (idx_of(s) != idx_of(p)));
    chk("wrap", wrap_pulse, s.wr);
    if (s.mode == 0 && s.amp == 255 && idx_of(s) == 64)
      chk("sine_peak", value, 255);
    if (s.mode == 0 && s.amp == 255 && idx_of(s) == 192)
      chk("sine_trough", value, 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic load(longint f, int m, int a);
    cfg_load = 1'b1;
    ftw      = f[31:0];
    mode     = m[1:0];
    amp      = a[7:0];
    cycle();
    cfg_load = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    en = 1'b0;
    phase_clr = 1'b0;
    cfg_load = 1'b0;
    ftw = '0;
    mode = '0;
    amp = '0;
    model_reset();
    @(negedge clk);
    chk("rst_value", value, 128);
    chk("rst_step", step_pulse, 0);
    chk("rst_wrap", wrap_pulse, 0);
    rst_n = 1'b1;
    run(20);

    load(64'd1 << 24, 2, 255);
    phase_clr = 1'b1;
    cycle();
    phase_clr = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 600; k++) begin
      cycle();
      if (wrap_pulse) chk("wrap_at_zero", value, 0);
    end

    load(64'd1 << 23, 2, 255);
    run(300);

    cfg_load = 1'b1;
    phase_clr = 1'b1;
    ftw = 32'd1 << 24;
    mode = 2'd0;
    amp = 8'd255;
    cycle();
    cfg_load = 1'b0;
    phase_clr = 1'b0;
    run(300);

    load(64'd1 << 24, 3, 127);
    run(300);
    load(64'd1 << 24, 3, 0);
    run(300);

    en = 1'b0;
    load(64'd1 << 24, 1, 200);
    run(10);
    load(0, 2, 255);
    en = 1'b1;
    run(20);

    for (int k = 0; k < 2000; k++) begin
      phase_clr = ($urandom_range(0, 19) == 0);
      en        = ($urandom_range(0, 9) != 0);
      cfg_load  = ($urandom_range(0, 15) == 0);
      mode      = 2'($urandom_range(0, 3));
      amp       = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: ftw = $urandom;
        1: ftw = 32'($urandom_range(1, 9)) << 24;
        2: ftw = 32'd0;
        default: ftw = 32'($urandom_range(1, 3)) << 23;
      endcase
      cycle();
    end
    phase_clr = 1'b0;
    cfg_load = 1'b0;

    en = 1'b1;
    load(64'd1 << 24, 2, 255);
    run(40);
    #2 rst_n = 1'b0;
    #1;
    chk("async_value", value, 128);
    chk("async_step", step_pulse, 0);
    chk("async_wrap", wrap_pulse, 0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(50);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_gen_dds.md
WAVE_GEN_DDS -- requirements
Module: wave_gen_dds

Interface
REQ-001 Parameter DATA_W, default 8, output code width and sample-index width (legal range 6..12).
REQ-002 Parameter PHASE_W, default 32, phase accumulator width (PHASE_W > DATA_W).
REQ-003 Parameter FTW_RST, default 32'd1374, frequency tuning word loaded at reset (about 16 Hz at 50 MHz, PHASE_W=32).
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  accumulate enable.
REQ-007 phase_clr  input  1  synchronous phase clear pulse.
REQ-008 cfg_load  input  1  latch ftw/mode/amp into active registers.
REQ-009 ftw  input  PHASE_W  frequency tuning word.
REQ-010 mode  input  2  waveform: 0 sine, 1 triangle, 2 sawtooth, 3 square.
REQ-011 amp  input  8  amplitude; gain = (amp+1)/256.
REQ-012 value  output  DATA_W  registered output code.
REQ-013 step_pulse  output  1  one-cycle pulse when value reflects a new sample index.
REQ-014 wrap_pulse  output  1  one-cycle pulse when value reflects a phase wrap.

Function
REQ-015 Active config registers (ftw_a, mode_a, amp_a) SHALL update only on a clk edge with cfg_load=1 and take effect from the following cycle.
REQ-016 Phase update per edge SHALL follow this priority: phase_clr=1 -> phase=0; else en=1 -> phase = phase + ftw_a modulo 2^PHASE_W; else hold.
REQ-017 Carry-out of the addition SHALL be recorded as a wrap event; phase_clr SHALL NOT generate a wrap event.
REQ-018 Sample index i SHALL be phase[PHASE_W-1 -: DATA_W]; MAX = 2^DATA_W-1; MID = 2^(DATA_W-1).
REQ-019 Sine raw SHALL be round(MAX/2*(1+sin(2*pi*i/2^DATA_W))), held in a constant table of 2^DATA_W entries generated at elaboration.
REQ-020 Triangle raw SHALL be {i[DATA_W-2:0],0} when i[MSB]=0, and the bitwise inverse of that value when i[MSB]=1.
REQ-021 Sawtooth raw SHALL be i.
REQ-022 Square raw SHALL be MAX when i[MSB]=0, and 0 otherwise.
REQ-023 Scaling SHALL compute d = raw - MID (signed), then value = MID + ((d*(amp_a+1)) >>> 8) using arithmetic floor; the result never leaves 0..MAX, so no clamp is required.
REQ-024 Pipeline SHALL be two stages: stage 1 = index/mode -> raw; stage 2 = scale -> value. A phase register state at edge k SHALL appear on value at edge k+2.
REQ-025 step_pulse SHALL be 1 for the cycle in which value reflects index i(k) != i(k-1), aligned with value.
REQ-026 wrap_pulse SHALL be 1 for the cycle in which value reflects a phase that was produced by a wrap event.
REQ-027 step_pulse and wrap_pulse SHALL be 1 together on a wrap that also changes the index.
REQ-028 With en=0, value SHALL settle to the held phase and pulses SHALL stay 0; changes to mode_a/amp_a still propagate through the pipeline with latency 2.
REQ-029 Simultaneous cfg_load and phase_clr SHALL both take effect on the same edge.
REQ-030 ftw_a = 0 SHALL freeze the phase and produce no pulses.

Reset
REQ-031 rst_n=0 SHALL asynchronously set phase=0, ftw_a=FTW_RST, mode_a=0, amp_a=255, value=MID, step_pulse=0, wrap_pulse=0, and clear all pipeline state, including index-history and wrap flags.
REQ-032 After reset release, no pulse SHALL be asserted until a genuine index change or wrap passes through the pipeline.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight samples.

Verification (DATA_W=8, PHASE_W=32)
REQ-034 Release reset with en=0 -> value=128, step_pulse=0, wrap_pulse=0, held indefinitely.
REQ-035 Load mode=2, amp=255, ftw=2^24, then pulse phase_clr and raise en -> after 2-cycle latency value=0,1,2,...,255,0; step_pulse every cycle; wrap_pulse once per 256 cycles, coincident with value=0.
REQ-036 Load ftw=2^23 in sawtooth mode -> value increments every other cycle; step_pulse has a 50% duty cycle.
REQ-037 Load mode=0, ftw=2^24, amp=255, phase_clr -> value sequence 128,131,134,...; index 64 gives 255; index 192 gives 0.
REQ-038 Load mode=3, amp=127 -> value alternates 191 (128 samples) and 64 (128 samples); amp=0 -> value is 128 (high half) and 127 (low half).
REQ-039 Run sawtooth, then assert rst_n=0 asynchronously between clock edges -> outputs immediately go to 128/0/0; after release, phase restarts from 0 with FTW_RST.
